column_approx_serial_ctrl: RTL and testbench

Sequential controller for the column-truncated approximate multiplier. It accepts one operand pair per transaction over a valid/ready handshake and computes the product bit-serially, one partial-product row per cycle. Rows below column THETA are truncated exactly as in the combinational column-approximate array, so results are bit-identical to that array at a fraction of its area. A per-transaction `approx_en` bit selects truncated or exact product, so one instance serves both accuracy modes.

---
 rtl/column_approx_serial_ctrl.sv | 88 ++++++++
 tb/tb_column_approx_serial_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/column_approx_serial_ctrl.sv
// Bit-serial column-truncated approximate multiplier: one partial-product row per cycle.
// Rows below THETA drop their low columns when approx_en was set at accept time.
module column_approx_serial_ctrl #(
  parameter int WIDTH = 8,
  parameter int THETA = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  input  logic                 approx_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   z,
  output logic                 busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   x_q, y_q;
  logic               approx_q;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;

  logic               accept;
  logic               last_row;
  logic [WIDTH-1:0]   row_mask;
  logic [WIDTH-1:0]   row;
  logic [2*WIDTH-1:0] term;

  // DONE with out_ready lets a new operand pair in on the same edge as the output handshake.
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign last_row  = (cnt == CNT_W'(WIDTH - 1));
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign z         = acc;

  // Truncated rows clear the THETA-i low bits of x, matching the combinational array.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    row_mask = '1;
    if (approx_q && (int'(cnt) < THETA))
      row_mask = {WIDTH{1'b1}} << (THETA - int'(cnt));
    row  = y_q[cnt] ? (x_q & row_mask) : '0;
    term = {{WIDTH{1'b0}}, row} << cnt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept)   state_nxt = RUN;
      RUN:  if (last_row) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = in_valid ? RUN : IDLE;
      default:            state_nxt = IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      approx_q <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        x_q      <= x;
        y_q      <= y;
        approx_q <= approx_en;
        cnt      <= '0;
        acc      <= '0;
      end else if (state == RUN) begin
        acc <= acc + term;
        cnt <= last_row ? '0 : cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_column_approx_serial_ctrl.sv
// Self-checking bench: directed table, multi-cycle corner sequences, and randomized
// traffic against a row-truncation reference model for THETA = 5, 0 and 8.
module tb_column_approx_serial_ctrl;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, approx_en, out_ready;
  logic [W-1:0] x, y;

  logic in_ready5, out_valid5, busy5;
  logic in_ready0, out_valid0, busy0;
  logic in_ready8, out_valid8, busy8;
  logic [2*W-1:0] z5, z0, z8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  column_approx_serial_ctrl #(.WIDTH(W), .THETA(5)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready5), .x(x), .y(y),
    .approx_en(approx_en), .out_valid(out_valid5), .out_ready(out_ready), .z(z5), .busy(busy5));
  column_approx_serial_ctrl #(.WIDTH(W), .THETA(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .x(x), .y(y),
    .approx_en(approx_en), .out_valid(out_valid0), .out_ready(out_ready), .z(z0), .busy(busy0));
  column_approx_serial_ctrl #(.WIDTH(W), .THETA(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8), .x(x), .y(y),
    .approx_en(approx_en), .out_valid(out_valid8), .out_ready(out_ready), .z(z8), .busy(busy8));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Sum of rows y[i]*x*2^i, with the THETA-i low bits of x cleared on truncated rows.
  function automatic logic [2*W-1:0] ref_prod(input int theta, input logic [W-1:0] a,
                                               input logic [W-1:0] b, input logic ap);
    logic [2*W-1:0] sum;
    logic [W-1:0]   r;
    sum = '0;
    for (int i = 0; i < W; i++) begin
      if (b[i]) begin
        r = a;
        if (ap && i < theta) begin
          r = r >> (theta - i);
          r = r << (theta - i);
        end
        sum = sum + ({{W{1'b0}}, r} << i);
      end
    end
    return sum;
  endfunction

  // Wait (bounded) for out_valid, counting edges; leaves time at posedge+1.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid5 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic ap,
                         output logic [2*W-1:0] r5, output logic [2*W-1:0] r0,
                         output logic [2*W-1:0] r8, output int lat);
    x = a; y = b; approx_en = ap; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    r5 = z5; r0 = z0; r8 = z8;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           ap;
    logic [2*W-1:0] z_exp;
  } vec_t;

  typedef struct {
    logic [2*W-1:0] e5;
    logic [2*W-1:0] e0;
    logic [2*W-1:0] e8;
  } exp_t;

  vec_t vecs[6];
  exp_t q[$];

  initial begin
    logic [2*W-1:0] r5, r0, r8, zh;
    int lat;
    bit stable, seen;
    int issued, done_cnt, cyc;
    bit acc_now;
    exp_t e;
    logic [W-1:0] ca, cb;
    logic cap;

    vecs[0] = '{8'hFF, 8'hFF, 1'b1, 16'hFD80};
    vecs[1] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    vecs[2] = '{8'h1F, 8'h01, 1'b1, 16'h0000};
    vecs[3] = '{8'h1F, 8'h01, 1'b0, 16'h001F};
    vecs[4] = '{8'h80, 8'h80, 1'b1, 16'h4000};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 16'h4000};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; approx_en = 1'b0; x = '0; y = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_flags", {in_ready5, out_valid5, busy5}, 3'b100);
    check("reset_z", z5, 16'h0000);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i].a, vecs[i].b, vecs[i].ap, r5, r0, r8, lat);
      check($sformatf("vec%0d_latency", i), lat, 8);
      check($sformatf("vec%0d_z_t5", i), r5, vecs[i].z_exp);
      check($sformatf("vec%0d_z_t0", i), r0, vecs[i].a * vecs[i].b);
      check($sformatf("vec%0d_z_t8", i), r8, ref_prod(8, vecs[i].a, vecs[i].b, vecs[i].ap));
    end

    // Output stall for 20 cycles, then back-to-back accept
    x = 8'hA5; y = 8'h3C; approx_en = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    check("hold_latency", lat, 8);
    check("hold_z", z5, ref_prod(5, 8'hA5, 8'h3C, 1'b1));
    zh = z5; stable = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (z5 !== zh || out_valid5 !== 1'b1 || busy5 !== 1'b1 || in_ready5 !== 1'b0) stable = 1'b0;
    end
    check("hold_stable", stable, 1'b1);
    x = 8'h5A; y = 8'hC3; approx_en = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("b2b_in_ready", in_ready5, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b_run_flags", {busy5, out_valid5, in_ready5}, 3'b100);
    wait_valid(lat);
    check("b2b_latency", lat, 8);
    check("b2b_z", z5, 16'h5A * 16'hC3);
    @(posedge clk); #1;

    // Operands toggled during RUN must not affect the result
    x = 8'hD7; y = 8'hB9; approx_en = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid5 && lat < 50) begin
      x = W'($urandom); y = W'($urandom); approx_en = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    check("toggle_latency", lat, 8);
    check("toggle_z_t5", z5, ref_prod(5, 8'hD7, 8'hB9, 1'b1));
    check("toggle_z_t0", z0, 16'hD7 * 16'hB9);
    check("toggle_z_t8", z8, ref_prod(8, 8'hD7, 8'hB9, 1'b1));
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Reset during the 4th RUN cycle
    x = 8'hFF; y = 8'hFF; approx_en = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_run_flags", {in_ready5, out_valid5, busy5}, 3'b100);
    check("rst_run_z", z5, 16'h0000);
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid5) seen = 1'b1;
    end
    check("rst_run_no_output", seen, 1'b0);

    // Reset in DONE with a pending result
    x = 8'h77; y = 8'h99; approx_en = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    check("rst_done_reached", out_valid5, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_done_flags", {in_ready5, out_valid5, busy5}, 3'b100);
    check("rst_done_z", z5, 16'h0000);

    // Reset beats a simultaneous accept
    x = 8'h12; y = 8'h34; in_valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    check("rst_vs_accept", {in_ready5, out_valid5, busy5}, 3'b100);
    @(posedge clk); #1;
    check("rst_vs_accept_idle", busy5, 1'b0);

    // Randomized traffic with stalls on both sides
    issued = 0; done_cnt = 0; cyc = 0;
    while ((issued < 3000 || q.size() > 0) && cyc < 60000) begin
      if (!in_valid && issued < 3000 && $urandom_range(0, 3) != 0) begin
        x = W'($urandom); y = W'($urandom); approx_en = 1'($urandom);
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc_now = 1'b0;
      if (in_valid && in_ready5) begin
        ca = x; cb = y; cap = approx_en;
        e.e5 = ref_prod(5, ca, cb, cap);
        e.e0 = ref_prod(0, ca, cb, cap);
        e.e8 = ref_prod(8, ca, cb, cap);
        q.push_back(e);
        issued++;
        acc_now = 1'b1;
      end
      if (out_valid5 && out_ready) begin
        if (q.size() == 0) begin
          check("rand_spurious_output", 1, 0);
        end else begin
          e = q.pop_front();
          check("rand_z_t5", z5, e.e5);
          check("rand_z_t0", z0, e.e0);
          check("rand_z_t8", z8, e.e8);
          check("rand_sync", {out_valid0, out_valid8, in_ready0, in_ready8, busy0, busy8}, 6'h3F);
        end
        done_cnt++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc_now) in_valid = 1'b0;
    end
    check("rand_no_timeout", (cyc < 60000), 1'b1);
    check("rand_count", done_cnt, issued);
    check("rand_queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
